// File: rtl/dmem_access_ctrl.sv
// Memory-stage sequencer: runs one req/ack data-memory access per load/store,
// holds the pipeline while it is outstanding and bounds the wait with a timeout.
module dmem_access_ctrl #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              MemtoRegM,
    input  logic              MemWriteM,
    input  logic [ADDR_W-1:0] ALUResultM,
    input  logic [DATA_W-1:0] WriteDataM,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              StallMem,
    output logic              FlushW,
    output logic [DATA_W-1:0] ReadDataM,
    output logic              MemFault
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             fault;
    logic             mem_access;

    assign mem_access = MemtoRegM | MemWriteM;

    // Access sequencer; mem_we doubles as the load/store tag of the access in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ReadDataM <= '0;
            wait_cnt  <= '0;
            fault     <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (mem_access) begin
                        mem_addr  <= ALUResultM;
                        mem_wdata <= WriteDataM;
                        mem_we    <= MemWriteM;
                        mem_req   <= 1'b1;
                        wait_cnt  <= '0;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                    // Ack takes priority over a timeout landing in the same cycle.
                    if (mem_ack) begin
                        if (!mem_we) begin
                            ReadDataM <= mem_rdata;
                        end
                        mem_req <= 1'b0;
                        state   <= S_DONE;
                    end else if (wait_cnt == CNT_LAST) begin
                        if (!mem_we) begin
                            ReadDataM <= '0;
                        end
                        mem_req <= 1'b0;
                        fault   <= 1'b1;
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Same instruction is still in M, so MemAccess is not looked at here.
                    fault <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Stall: live in IDLE so the access cycle itself is held, forced in WAIT, released in DONE.
    always_comb begin
        StallMem = 1'b0;
        unique case (state)
            S_IDLE:  StallMem = mem_access;
            S_WAIT:  StallMem = 1'b1;
            S_DONE:  StallMem = 1'b0;
            default: StallMem = 1'b0;
        endcase
    end

    assign FlushW   = StallMem;
    assign MemFault = fault;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Randomized bench for dmem_access_ctrl against a transaction-level timeline model.
module tb_dmem_access_ctrl;

    localparam int unsigned TO = 8;

    logic        clk;
    logic        reset_n;
    logic        MemtoRegM;
    logic        MemWriteM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        StallMem;
    logic        FlushW;
    logic [31:0] ReadDataM;
    logic        MemFault;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_rdata;

    dmem_access_ctrl #(
        .TIMEOUT(TO),
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .MemtoRegM (MemtoRegM),
        .MemWriteM (MemWriteM),
        .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .StallMem  (StallMem),
        .FlushW    (FlushW),
        .ReadDataM (ReadDataM),
        .MemFault  (MemFault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One access whose ack arrives in WAIT cycle d (d > TO means never acked).
    task automatic do_access(input bit is_load, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata,
                             input int d);
        int  w;
        bit  timed_out;
        w         = (d < int'(TO)) ? d : int'(TO);
        timed_out = (d > int'(TO));

        next_cycle();
        MemtoRegM  = is_load;
        MemWriteM  = !is_load;
        ALUResultM = addr;
        WriteDataM = wdata;
        mem_ack    = 1'b0;
        mem_rdata  = $urandom;
        #2;
        check("start_stall", 64'(StallMem), 64'd1);
        check("start_flush", 64'(FlushW), 64'd1);
        check("start_req", 64'(mem_req), 64'd0);

        for (int k = 1; k <= w; k++) begin
            next_cycle();
            // Scramble M-stage operands to prove the request payload is latched.
            ALUResultM = $urandom;
            WriteDataM = $urandom;
            mem_ack    = (k == d);
            mem_rdata  = (k == d) ? rdata : $urandom;
            #2;
            check("wait_req", 64'(mem_req), 64'd1);
            check("wait_addr", 64'(mem_addr), 64'(addr));
            check("wait_we", 64'(mem_we), 64'(!is_load));
            if (!is_load) check("wait_wdata", 64'(mem_wdata), 64'(wdata));
            check("wait_stall", 64'(StallMem), 64'd1);
            check("wait_flush", 64'(FlushW), 64'd1);
            check("wait_fault", 64'(MemFault), 64'd0);
            check("wait_rdata", 64'(ReadDataM), 64'(exp_rdata));
        end

        if (is_load) exp_rdata = timed_out ? 32'd0 : rdata;

        next_cycle();
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        #2;
        check("done_stall", 64'(StallMem), 64'd0);
        check("done_flush", 64'(FlushW), 64'd0);
        check("done_req", 64'(mem_req), 64'd0);
        check("done_fault", 64'(MemFault), 64'(timed_out));
        check("done_rdata", 64'(ReadDataM), 64'(exp_rdata));
    endtask

    task automatic idle_cycle(input bit spurious);
        next_cycle();
        MemtoRegM = 1'b0;
        MemWriteM = 1'b0;
        mem_ack   = spurious;
        mem_rdata = $urandom;
        #2;
        check("idle_stall", 64'(StallMem), 64'd0);
        check("idle_req", 64'(mem_req), 64'd0);
        check("idle_fault", 64'(MemFault), 64'd0);
        check("idle_rdata", 64'(ReadDataM), 64'(exp_rdata));
    endtask

    initial begin
        reset_n    = 1'b0;
        MemtoRegM  = 1'b0;
        MemWriteM  = 1'b0;
        ALUResultM = '0;
        WriteDataM = '0;
        mem_ack    = 1'b0;
        mem_rdata  = '0;
        exp_rdata  = '0;
        #2;
        check("rst_req", 64'(mem_req), 64'd0);
        check("rst_we", 64'(mem_we), 64'd0);
        check("rst_addr", 64'(mem_addr), 64'd0);
        check("rst_wdata", 64'(mem_wdata), 64'd0);
        check("rst_rdata", 64'(ReadDataM), 64'd0);
        check("rst_fault", 64'(MemFault), 64'd0);
        check("rst_stall", 64'(StallMem), 64'd0);
        MemtoRegM = 1'b1;
        #1;
        check("rst_stall_follow", 64'(StallMem), 64'd1);
        check("rst_flush_follow", 64'(FlushW), 64'd1);
        MemtoRegM = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle_cycle(1'b0);

        // Directed cases.
        do_access(1'b1, 32'h100, 32'h0, 32'hDEADBEEF, 1);
        idle_cycle(1'b0);
        do_access(1'b0, 32'h40, 32'h12345678, 32'hCAFEF00D, 5);
        idle_cycle(1'b0);
        do_access(1'b1, 32'h200, 32'h0, 32'h55AA55AA, int'(TO) + 1);
        idle_cycle(1'b0);
        do_access(1'b1, 32'h300, 32'h0, 32'hA5A5F00F, int'(TO));
        idle_cycle(1'b0);

        // Reset in the 3rd WAIT cycle.
        next_cycle();
        MemtoRegM  = 1'b1;
        MemWriteM  = 1'b0;
        ALUResultM = 32'h500;
        mem_ack    = 1'b0;
        next_cycle();
        next_cycle();
        next_cycle();
        #1;
        reset_n   = 1'b0;
        exp_rdata = '0;
        #1;
        check("mid_rst_req", 64'(mem_req), 64'd0);
        check("mid_rst_rdata", 64'(ReadDataM), 64'd0);
        check("mid_rst_addr", 64'(mem_addr), 64'd0);
        check("mid_rst_stall", 64'(StallMem), 64'd1);
        MemtoRegM = 1'b0;
        #1;
        check("mid_rst_stall_off", 64'(StallMem), 64'd0);
        next_cycle();
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0BAD0;
        next_cycle();
        reset_n = 1'b1;
        mem_ack = 1'b0;
        idle_cycle(1'b1);
        idle_cycle(1'b0);
        do_access(1'b1, 32'h600, 32'h0, 32'h0BADCAFE, 2);

        // Back-to-back loads, then a spurious ack in IDLE.
        do_access(1'b1, 32'h700, 32'h0, 32'h11111111, 1);
        do_access(1'b1, 32'h704, 32'h0, 32'h22222222, 1);
        idle_cycle(1'b1);
        idle_cycle(1'b0);

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            int gap;
            do_access(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                      int'($urandom_range(1, TO + 2)));
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) idle_cycle(1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Sequencer for a multi-cycle data memory behind the pipeline's Memory stage. When the instruction in M is a load or store, it issues a req/ack transaction to the data memory, stalls Fetch, Decode, Execute and Memory, and bubbles Writeback until the access completes. Its stall output is OR-ed with the load-use stall in the hazard logic. A timeout counter bounds the wait and flags a memory fault.

## Interface
Parameters:
- TIMEOUT, 64, maximum WAIT cycles before an access is abandoned (≥2)
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports:
- clk  in  1  pipeline clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- MemtoRegM  in  1  instruction in M is a load
- MemWriteM  in  1  instruction in M is a store
- ALUResultM  in  ADDR_W  access address
- WriteDataM  in  DATA_W  store data
- mem_req  out  1  request to data memory (registered)
- mem_we  out  1  write enable (registered)
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  DATA_W  latched store data
- mem_ack  in  1  memory completion, one cycle
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- StallMem  out  1  stall F, D, E and M pipeline registers
- FlushW  out  1  load a bubble into the M/W register
- ReadDataM  out  DATA_W  captured load data
- MemFault  out  1  one-cycle pulse when an access times out

## Operation
- The FSM has three states: IDLE, WAIT and DONE.
- MemAccess = MemtoRegM | MemWriteM.
- IDLE:
  - StallMem = MemAccess (combinational).
  - If MemAccess is 1: at the clock edge, latch ALUResultM to mem_addr, WriteDataM to mem_wdata and MemWriteM to mem_we; set mem_req=1; clear the timeout counter; go to WAIT.
- WAIT:
  - StallMem=1. mem_req, mem_we, mem_addr and mem_wdata hold stable.
  - The counter increments every cycle.
  - If mem_ack=1: capture mem_rdata into ReadDataM (loads only; stores leave ReadDataM unchanged), drop mem_req at the edge, go to DONE.
  - Else, if the counter equals TIMEOUT-1: drop mem_req, set ReadDataM=0 for a load, set the fault flag, go to DONE.
  - If ack and timeout occur in the same cycle, ack wins and no fault is raised.
- DONE:
  - StallMem=0, so the pipeline advances at the end of this cycle.
  - MemFault=1 if the fault flag is set. The flag clears at the edge.
  - Always go to IDLE. MemAccess is ignored here because the same instruction is still in M.
- FlushW = StallMem in all states.
- mem_ack received in IDLE or DONE is ignored.
- Counter width is clog2(TIMEOUT+1). It never wraps: it stops counting when it leaves WAIT.

## Timing
- Reset (asynchronous, immediate, including mid-access) forces:
  - state=IDLE
  - mem_req=0, mem_we=0
  - mem_addr=0, mem_wdata=0, ReadDataM=0
  - counter=0, fault flag=0, MemFault=0
- After reset, StallMem and FlushW follow MemAccess combinationally.
- Access detected in cycle t:
  - mem_req is high from t+1.
  - The earliest ack is at t+1; DONE is then t+2.
  - Minimum stall is 2 cycles (t, t+1). The pipeline advances at the end of t+2.
- Ack at cycle u: ReadDataM is valid from u+1 and holds until the next load completes.
- Timeout: mem_req is high for exactly TIMEOUT cycles. MemFault pulses in the cycle after the last WAIT cycle.
- Back-to-back memory instructions: the second enters M after DONE. IDLE starts its access in the same cycle, with no dead cycle beyond the inherent 2-cycle stall.
- mem_req never deasserts before ack or timeout.
- mem_addr, mem_wdata and mem_we never change while mem_req=1.

## Test plan
- **Load, ack in 1 cycle.**
  - Stimulus: MemtoRegM=1, ALUResultM=0x100; mem_ack=1 with mem_rdata=0xDEADBEEF one cycle after mem_req rises.
  - Required: StallMem=1 for 2 cycles; mem_addr=0x100, mem_we=0; ReadDataM=0xDEADBEEF in DONE; StallMem=0 in DONE.
- **Store, ack after 5 WAIT cycles.**
  - Stimulus: MemWriteM=1, ALUResultM=0x40, WriteDataM=0x12345678.
  - Required: mem_we=1, mem_wdata=0x12345678 stable for all 5 cycles; ReadDataM unchanged; StallMem=1 and FlushW=1 for 6 cycles.
- **Timeout, TIMEOUT=8, no ack.**
  - Required: mem_req high for exactly 8 cycles; ReadDataM=0; MemFault=1 for exactly 1 cycle; FSM back in IDLE.
- **Ack on the timeout cycle.**
  - Stimulus: mem_ack in the 8th WAIT cycle with TIMEOUT=8.
  - Required: data captured; MemFault stays 0.
- **Reset mid-access.**
  - Stimulus: reset_n=0 in the 3rd WAIT cycle.
  - Required: mem_req=0, ReadDataM=0 and StallMem=MemAccess immediately; a later ack is ignored; the next access proceeds normally.
- **Back-to-back loads, plus a spurious ack.**
  - Stimulus: two consecutive loads, each acked after 1 cycle; an extra mem_ack pulse in IDLE.
  - Required: each load stalls exactly 2 cycles; both data values captured in order; the spurious ack causes no state change.
